// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
// FSM states, owner encodings and counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // LAT is at most 15, so LAT-1 fits in four bits.
    localparam int CNT_W = 4;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port word memory between IF and MEM-stage requesters.
// Ports: clk/rst, IF request/addr/rdata/stall, D read/write/addr/wdata/
// rdata/stall, and the mem_* strobes, address and data to the array.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               owner;
    logic               last_owner;
    logic [ADDR_W-1:0]  a_addr;
    logic [DATA_W-1:0]  a_wdata;
    logic               a_write;

    logic               d_req;
    logic               grant;
    logic               grant_own;
    logic               cnt_zero;
    logic               in_resp;

    assign d_req    = dm_read | dm_write;
    assign cnt_zero = (cnt == '0);
    assign in_resp  = (state == RESP);

    // Grant picker and next state. In RESP only the non-owner may be
    // granted: the owner's request is the one completing this cycle.
    always_comb begin
        grant     = 1'b0;
        grant_own = OWN_I;
        state_nx  = state;
        unique case (state)
            IDLE: begin
                if (if_req && d_req) begin
                    grant     = 1'b1;
                    grant_own = ~last_owner;
                end else if (d_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_D;
                end else if (if_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_I;
                end
                state_nx = grant ? ACC : IDLE;
            end
            ACC: begin
                state_nx = cnt_zero ? RESP : ACC;
            end
            RESP: begin
                if (owner == OWN_D && if_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_I;
                end else if (owner == OWN_I && d_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_D;
                end
                state_nx = grant ? ACC : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            a_addr     <= '0;
            a_wdata    <= '0;
            a_write    <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner <= grant_own;
                cnt   <= CNT_W'(LAT - 1);
                if (grant_own == OWN_D) begin
                    a_addr  <= dm_addr;
                    a_wdata <= dm_wdata;
                    // read+write together is treated as a read
                    a_write <= dm_write & ~dm_read;
                end else begin
                    a_addr  <= if_addr;
                    a_wdata <= '0;
                    a_write <= 1'b0;
                end
            end else if (state == ACC) begin
                if (!cnt_zero) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    last_owner <= owner;
                    if (!a_write) begin
                        if (owner == OWN_D) begin
                            dm_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end
                end
            end
        end
    end

    assign mem_addr  = a_addr;
    assign mem_wdata = a_wdata;
    assign mem_read  = (state == ACC) & ~a_write;
    // Reset wins over the commit cycle so no write escapes a reset.
    assign mem_write = (state == ACC) & a_write & cnt_zero & ~rst;

    assign if_stall = if_req & ~(in_resp & (owner == OWN_I));
    assign dm_stall = d_req  & ~(in_resp & (owner == OWN_D));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter.
// Memory word i is preloaded with i*10.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [4:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_read;
    logic        dm_write;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic [4:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    unified_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [8];
    logic        mem_init;
    assign mem_rdata = mem[mem_addr[4:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'(i * 10);
        end else if (mem_write) begin
            mem[mem_addr[4:2]] <= mem_wdata;
        end
    end

    int         wr_cnt = 0;
    logic [4:0] wr_addr = '0;
    int         cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
        end
    end

    // longest run of consecutive stall cycles per requester
    logic clr_max = 1'b0;
    int   if_run = 0, d_run = 0, if_max = 0, d_max = 0;
    always @(negedge clk) begin
        if_run <= if_stall ? if_run + 1 : 0;
        d_run  <= dm_stall ? d_run + 1 : 0;
        if (clr_max) begin
            if_max <= 0;
            d_max  <= 0;
        end else begin
            if (if_stall && if_run + 1 > if_max) if_max <= if_run + 1;
            if (dm_stall && d_run + 1 > d_max)   d_max  <= d_run + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic        own;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   resp_cnt = 0;

    task automatic push(input logic own, input logic rd,
                        input logic [31:0] d);
        exp_t e;
        e.own  = own;
        e.rd   = rd;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic handle(input logic own, input logic [31:0] rd);
        exp_t e;
        resp_cnt++;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: owner %0d responded, expected none",
                     own);
        end else begin
            e = q.pop_front();
            check("sb_owner", 32'(own), 32'(e.own));
            if (e.rd) check("sb_rdata", rd, e.data);
        end
    endtask

    // monitor: a response cycle is a pending request with its stall low
    always @(negedge clk) begin
        if (!rst) begin
            if (if_req && !if_stall) handle(OWN_I, if_rdata);
            if ((dm_read || dm_write) && !dm_stall) handle(OWN_D, dm_rdata);
        end
    end

    task automatic wait_d(output int stalls, output int t, input bit drop);
        stalls = 0;
        t = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!dm_stall) begin
                t = cyc;
                if (drop) begin
                    @(posedge clk);
                    #1;
                    dm_read  = 1'b0;
                    dm_write = 1'b0;
                end
                return;
            end
            stalls++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL d_timeout: dm_stall stuck high, expected release");
    endtask

    task automatic wait_i(output int stalls, output int t, input bit drop);
        stalls = 0;
        t = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!if_stall) begin
                t = cyc;
                if (drop) begin
                    @(posedge clk);
                    #1;
                    if_req = 1'b0;
                end
                return;
            end
            stalls++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL i_timeout: if_stall stuck high, expected release");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    int st, sd, si, t0, t1, td, ti, wr0, r0;

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_mem_bus", {mem_read, mem_write, mem_addr}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        // uncontested D read of word 3
        dm_read = 1'b1;
        dm_addr = 5'h0C;
        push(OWN_D, 1'b1, 32'd30);
        wait_d(st, t0, 1'b1);
        check("t1_dstall_cycles", st, LAT + 1);
        check("t1_no_write", wr_cnt, 0);

        // IF only, two fetches with if_req held
        if_req  = 1'b1;
        if_addr = 5'h00;
        push(OWN_I, 1'b1, 32'd0);
        wait_i(st, t0, 1'b0);
        check("t2_istall_a", st, LAT + 1);
        @(posedge clk);
        #1;
        if_addr = 5'h04;
        push(OWN_I, 1'b1, 32'd10);
        wait_i(st, t1, 1'b1);
        check("t2_istall_b", st, LAT + 1);
        check("t2_fetch_period", t1 - t0, LAT + 2);

        // simultaneous IF read and D write after reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        if_req   = 1'b1;
        if_addr  = 5'h10;
        dm_write = 1'b1;
        dm_addr  = 5'h08;
        dm_wdata = 32'hDEAD;
        push(OWN_D, 1'b0, 32'd0);
        push(OWN_I, 1'b1, 32'd40);
        fork
            wait_d(sd, td, 1'b1);
            wait_i(si, ti, 1'b1);
        join
        check("t3_dstall_cycles", sd, LAT + 1);
        check("t3_istall_cycles", si, 2 * LAT + 2);
        check("t3_stall_gap", ti - td, LAT + 1);
        check("t3_write_count", wr_cnt, 1);
        check("t3_write_addr", wr_addr, 5'h08);
        check("t3_mem_word2", mem[2], 32'hDEAD);

        // starvation: both held, grants must alternate D, I, D, I
        @(posedge clk);
        #1;
        clr_max = 1'b1;
        @(posedge clk);
        #1;
        clr_max = 1'b0;
        r0 = resp_cnt;
        dm_read = 1'b1;
        dm_addr = 5'h0C;
        if_req  = 1'b1;
        if_addr = 5'h04;
        push(OWN_D, 1'b1, 32'd30);
        push(OWN_I, 1'b1, 32'd10);
        push(OWN_D, 1'b1, 32'd30);
        push(OWN_I, 1'b1, 32'd10);
        for (int i = 0; i < 100 && resp_cnt < r0 + 4; i++) @(negedge clk);
        check("t4_resp_count", resp_cnt - r0, 4);
        @(posedge clk);
        #1;
        dm_read = 1'b0;
        if_req  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t4_if_max_ok", 32'(if_max <= 2 * LAT + 2), 1);
        check("t4_d_max_ok", 32'(d_max <= 2 * LAT + 2), 1);

        // reset while a write is in ACC with cnt=1
        wr0      = wr_cnt;
        dm_write = 1'b1;
        dm_addr  = 5'h14;
        dm_wdata = 32'hBEEF;
        @(posedge clk);
        #1;
        check("t5_in_acc_addr", mem_addr, 5'h14);
        check("t5_in_acc_nowr", mem_write, 0);
        rst      = 1'b1;
        dm_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_mem_bus", {mem_read, mem_write, mem_addr}, 0);
        check("t5_mem_wdata", mem_wdata, 0);
        check("t5_rdata", if_rdata | dm_rdata, 0);
        check("t5_stalls", {if_stall, dm_stall}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_write", wr_cnt, wr0);
        check("t5_mem_word5", mem[5], 32'd50);

        // read and write together act as a read
        dm_read  = 1'b1;
        dm_write = 1'b1;
        dm_addr  = 5'h0C;
        dm_wdata = 32'h1234;
        push(OWN_D, 1'b1, 32'd30);
        wait_d(st, t0, 1'b1);
        check("t6_dstall_cycles", st, LAT + 1);
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_write", wr_cnt, wr0);
        check("t6_mem_word3", mem[3], 32'd30);

        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequences and shares one single-port 32-bit word memory between the instruction-fetch (IF) requester and the data-memory (MEM-stage) requester of the pipelined MIPS core. It latches a request, drives the memory for a fixed access latency, and returns read data in a registered response cycle. It also produces per-requester stall signals that the hazard unit uses to freeze PC and pipeline registers. Arbitration is round-robin between the two requesters.

## Interface
- ADDR_W, 5, byte address width; the word index is address[ADDR_W-1:2].
- DATA_W, 32, data width.
- LAT, 2, memory access cycles; legal range is 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  instruction fetch request; held until if_stall is low.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  DATA_W  fetched instruction; valid in the IF response cycle.
- if_stall  out  1  freeze IF/PC.
- dm_read  in  1  data read request.
- dm_write  in  1  data write request.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  load data; valid in the D response cycle.
- dm_stall  out  1  freeze the MEM stage and everything older.
- mem_addr  out  ADDR_W  address to the memory array.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  DATA_W  write data to the memory array.
- mem_rdata  in  DATA_W  memory read data; combinational from mem_addr.

## Operation
- States:
  - IDLE: no access in flight.
  - ACC: access in flight; the owner register is I or D; a down-counter cnt runs.
  - RESP: single cycle; the owner's stall is dropped.
- Request definitions: d_req = dm_read | dm_write. If dm_read and dm_write are both high, the access is a read and no write is issued, matching the data-memory write rule.
- Grant, evaluated in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the requester that was not granted last (the last_owner register). last_owner resets to I, so D wins the first conflict.
- On grant:
  - Latch address, write data and the read/write kind from the winner.
  - Load cnt = LAT-1, set owner, go to ACC.
- ACC:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_read is high for the whole of a read access.
  - mem_write is high only in the cycle where cnt==0, so exactly one write per access.
  - cnt decrements each cycle.
  - At cnt==0: for a read, capture mem_rdata into the owner's rdata register; update last_owner; go to RESP.
- RESP:
  - If the non-owner requester is pending, grant it directly (go to ACC).
  - Otherwise go to IDLE.
  - The owner's request in RESP is the one being completed and is never re-granted.
- Stalls are combinational:
  - if_stall = if_req & ~(RESP & owner==I).
  - dm_stall = d_req & ~(RESP & owner==D).
- A requester that drops its request mid-access does not abort the access. The access completes, writes still commit, and read data is still captured.
- if_rdata and dm_rdata hold their value until the next capture into the same register.

## Timing
- Reset values: state IDLE; cnt 0; last_owner I; if_rdata and dm_rdata 0; mem_read, mem_write, mem_addr and mem_wdata 0.
- Reset in any state, including mid-ACC, returns to IDLE next edge with no write strobe issued, because reset has priority over the cnt==0 write cycle.
- Uncontested access:
  - Request seen in IDLE at cycle 0.
  - ACC occupies cycles 1..LAT.
  - RESP is cycle LAT+1.
  - Stall is high in cycles 0..LAT (LAT+1 stall cycles).
  - Read data is valid in cycle LAT+1.
- Back-to-back accesses of alternating owners take LAT+1 cycles each (RESP overlaps the next grant). Same-owner repeats take LAT+2 cycles.
- Address/data inputs are sampled only at the grant edge; later changes are ignored.
- The memory array writes on the edge that ends the cnt==0 cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - State enum {IDLE, ACC, RESP}.
  - Owner constants OWN_I=1'b0 and OWN_D=1'b1.
  - cnt width derived from LAT (4 bits).
- No sub-module. The grant picker, counter and FSM fit in a single module (about 150–200 lines).

## Test plan
- Reset with LAT=2, memory word 3 = 30:
  - Stimulus: dm_read with dm_addr=5'h0C.
  - Required: dm_stall high for 3 cycles; dm_rdata=30 in cycle 3; mem_write never high.
- IF only:
  - Stimulus: if_req held high with if_addr 0, then 4.
  - Required: each fetch takes 4 cycles (IDLE→ACC×2→RESP→IDLE); if_rdata matches words 0 and 1.
- Simultaneous requests after reset:
  - Stimulus: if_req and dm_write (dm_addr=8, dm_wdata=0xDEAD) asserted together.
  - Required: D is granted first; mem_write is high for exactly one cycle with mem_addr=8; IF is granted straight from RESP; if_stall drops 3 cycles after dm_stall drops.
- Starvation check:
  - Stimulus: dm_read and if_req held continuously.
  - Required: grants alternate D, I, D, I; neither stall stays high more than 2·LAT+2 cycles.
- Reset mid-ACC of a write (cnt=1):
  - Required: no mem_write pulse; memory word unchanged; all outputs 0 the next cycle.
- dm_read=dm_write=1:
  - Required: treated as a read; mem_write stays 0; dm_rdata returns the stored word.
